udp_tx_arbiter: RTL and testbench
=================================

Name: udp_tx_arbiter

Overview:
- Round-robin arbiter that shares a single UDP TX encapsulation path between NUM_SRC independent application sources.
- Each source presents a UDP header (ports, length) plus an AXI-Stream payload.
- The block grants one source at a time, forwards its header, then passes its payload through until tlast.
- It sits between the application/socket layer and the UDP TX encapsulator, which feeds IP TX.

Parameters:
AXI_DATA_WIDTH, 8, payload beat width in bits
NUM_SRC, 4, number of requesting sources (2..8)
IDX_W, $clog2(NUM_SRC), width of the grant index

Ports:
i_clk  input  1  clock
i_reset  input  1  synchronous, active-high reset
s_hdr_tvalid  input  NUM_SRC  per-source header valid
s_hdr_trdy  output  NUM_SRC  per-source header accept
s_udp_src_port  input  16*NUM_SRC  per-source source port, source k at [16k+15:16k]
s_udp_dst_port  input  16*NUM_SRC  per-source destination port
s_udp_length  input  16*NUM_SRC  per-source UDP length (header + payload bytes)
s_axis_tdata  input  AXI_DATA_WIDTH*NUM_SRC  per-source payload data
s_axis_tvalid  input  NUM_SRC  per-source payload valid
s_axis_tlast  input  NUM_SRC  per-source payload last
s_axis_trdy  output  NUM_SRC  per-source payload ready
m_udp_hdr_tvalid  output  1  header valid to UDP TX
m_udp_hdr_trdy  input  1  header ready from UDP TX
m_udp_src_port  output  16  granted source port
m_udp_dst_port  output  16  granted destination port
m_udp_length  output  16  granted UDP length
m_axis_tdata  output  AXI_DATA_WIDTH  payload data to UDP TX
m_axis_tvalid  output  1  payload valid
m_axis_tlast  output  1  payload last
m_axis_trdy  input  1  payload ready
o_grant_idx  output  IDX_W  index of current or last granted source
o_busy  output  1  high in HDR or PAYLOAD

Behaviour:
- Reset (sync, active-high; overrides everything including mid-packet):
  - State = IDLE.
  - m_udp_hdr_tvalid=0, m_axis_tvalid=0, all s_hdr_trdy=0, all s_axis_trdy=0, o_busy=0.
  - Header output regs = 0, o_grant_idx=0.
  - RR pointer = NUM_SRC-1, so source 0 wins first.
  - A packet in flight is abandoned; the upstream source must restart it.
- States: IDLE, HDR, PAYLOAD.
- IDLE:
  - Winner = first asserted s_hdr_tvalid scanning from pointer+1 upward, modulo NUM_SRC.
  - If any request: s_hdr_trdy[winner]=1 combinationally this cycle (only that bit).
  - At the clock edge: latch the winner's src/dst/length into output regs, grant_idx<=winner, state<=HDR.
  - No requests: stay in IDLE; all trdy low.
- HDR:
  - m_udp_hdr_tvalid=1; fields held stable.
  - On m_udp_hdr_trdy: tvalid drops next cycle, state<=PAYLOAD.
  - Header-out latency: 1 cycle after the source header handshake.
- PAYLOAD (zero-latency combinational pass-through of the granted source):
  - m_axis_tdata/tvalid/tlast = s_axis_*[grant_idx].
  - s_axis_trdy[grant_idx] = m_axis_trdy; all other s_axis_trdy = 0.
  - On the beat where m_axis_tvalid & m_axis_trdy & m_axis_tlast: pointer<=grant_idx, state<=IDLE.
  - Single-beat payload (tlast on first beat) is legal.
- Outside PAYLOAD: m_axis_tvalid=0 and all s_axis_trdy=0. Non-granted sources' payload beats stall and are never dropped or reordered.
- Fairness: after source k's tlast, source k has the lowest priority in the next arbitration. With N continuously requesting sources, each is granted once per N packets.
- Inter-packet bubble: minimum 1 IDLE cycle + HDR cycles; header handshake and payload never overlap.
- s_hdr_tvalid deasserting while not granted is tolerated; no sticky request state.
- Length field is forwarded unchecked; consistency with beat count is the source's responsibility.
- o_grant_idx holds its value in IDLE; o_busy = (state != IDLE).

Decomposition:
- Shared udp_pkg:
  - state enum (IDLE/HDR/PAYLOAD);
  - UDP_HDR_BYTES=8;
  - port/length field width constant (16).
- One sub-module, rr_arbiter:
  - combinational rotate-priority pick;
  - inputs request vector and pointer; outputs one-hot grant, index, any-valid.
  - The pointer register stays in udp_tx_arbiter.

Test Plan:
- Single source 2 (NUM_SRC=4): hdr {src=0x1234, dst=0x0050, len=12}, 4 payload beats 0xA0..0xA3 -> s_hdr_trdy=4'b0100 for one cycle; m_udp_hdr_tvalid one cycle later with matching fields; m_axis carries 0xA0..0xA3 with tlast on 0xA3; grant_idx=2.
- All 4 sources request continuously, 2-beat packets -> grant order 0,1,2,3,0,1; no beat from a non-granted source appears on m_axis.
- m_axis_trdy toggles 1,0,0,1 during a 3-beat payload; m_udp_hdr_trdy held low 5 cycles -> data/last held stable while stalled; no beat lost or duplicated; header fields constant until accepted.
- Source 1 mid-payload while source 3 asserts hdr_tvalid -> source 3 sees s_hdr_trdy=0 until source 1's tlast handshake, then is granted next.
- 1-beat packet (tlast on first beat, len=9) -> single m_axis beat with tlast=1; return to IDLE; next grant works.
- i_reset pulsed after 2 of 5 payload beats -> next cycle all trdy=0, m_axis_tvalid=0, m_udp_hdr_tvalid=0, o_busy=0; with source 0 and 3 requesting, the first grant after reset is source 0.

Source files
------------

// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared UDP TX arbiter types and constants
package udp_pkg;

  localparam int UDP_HDR_BYTES = 8;
  localparam int UDP_FIELD_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority pick starting after ptr
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the source right after ptr overwrites last and wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand_idx  = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      cand_idx = IDX_W'((int'(ptr) + i) % NUM_SRC);
      if (req[cand_idx]) begin
        grant           = '0;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
        any             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - round-robin share of one UDP TX header+payload path
module udp_tx_arbiter
  import udp_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 8,
  parameter int NUM_SRC        = 4,
  parameter int IDX_W          = $clog2(NUM_SRC)
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic [NUM_SRC-1:0]                s_hdr_tvalid,
  output logic [NUM_SRC-1:0]                s_hdr_trdy,
  input  logic [16*NUM_SRC-1:0]             s_udp_src_port,
  input  logic [16*NUM_SRC-1:0]             s_udp_dst_port,
  input  logic [16*NUM_SRC-1:0]             s_udp_length,
  input  logic [AXI_DATA_WIDTH*NUM_SRC-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]                s_axis_tvalid,
  input  logic [NUM_SRC-1:0]                s_axis_tlast,
  output logic [NUM_SRC-1:0]                s_axis_trdy,
  output logic                              m_udp_hdr_tvalid,
  input  logic                              m_udp_hdr_trdy,
  output logic [15:0]                       m_udp_src_port,
  output logic [15:0]                       m_udp_dst_port,
  output logic [15:0]                       m_udp_length,
  output logic [AXI_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_trdy,
  output logic [IDX_W-1:0]                  o_grant_idx,
  output logic                              o_busy
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic [UDP_FIELD_W-1:0] src_port_q, src_port_d;
  logic [UDP_FIELD_W-1:0] dst_port_q, dst_port_d;
  logic [UDP_FIELD_W-1:0] length_q, length_d;

  logic [NUM_SRC-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               in_payload;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (s_hdr_tvalid),
    .ptr       (ptr_q),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  // Reset masks every handshake output in the same cycle, even mid-packet.
  always_comb begin
    in_payload       = (state_q == ST_PAYLOAD) && !i_reset;
    m_axis_tdata     = s_axis_tdata[int'(grant_idx_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    m_axis_tvalid    = in_payload && s_axis_tvalid[grant_idx_q];
    m_axis_tlast     = in_payload && s_axis_tlast[grant_idx_q];
    s_axis_trdy      = '0;
    if (in_payload) begin
      s_axis_trdy[grant_idx_q] = m_axis_trdy;
    end
    s_hdr_trdy       = ((state_q == ST_IDLE) && win_any && !i_reset) ? win_onehot : '0;
    m_udp_hdr_tvalid = (state_q == ST_HDR) && !i_reset;
    o_busy           = (state_q != ST_IDLE) && !i_reset;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    src_port_d  = src_port_q;
    dst_port_d  = dst_port_q;
    length_d    = length_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          src_port_d  = s_udp_src_port[int'(win_idx)*UDP_FIELD_W +: UDP_FIELD_W];
          dst_port_d  = s_udp_dst_port[int'(win_idx)*UDP_FIELD_W +: UDP_FIELD_W];
          length_d    = s_udp_length[int'(win_idx)*UDP_FIELD_W +: UDP_FIELD_W];
          grant_idx_d = win_idx;
          state_d     = ST_HDR;
        end
      end
      ST_HDR: begin
        if (m_udp_hdr_trdy) begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (m_axis_tvalid && m_axis_trdy && m_axis_tlast) begin
          ptr_d   = grant_idx_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(NUM_SRC - 1);
      grant_idx_q <= '0;
      src_port_q  <= '0;
      dst_port_q  <= '0;
      length_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      src_port_q  <= src_port_d;
      dst_port_q  <= dst_port_d;
      length_q    <= length_d;
    end
  end

  assign m_udp_src_port = src_port_q;
  assign m_udp_dst_port = dst_port_q;
  assign m_udp_length   = length_q;
  assign o_grant_idx    = grant_idx_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb/tb_udp_tx_arbiter.sv - scoreboard bench for udp_tx_arbiter
module tb_udp_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] ln;
    logic [1:0]  idx;
  } hdr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0]  sp_a [N];
  logic [15:0]  dp_a [N];
  logic [15:0]  ln_a [N];
  logic [W-1:0] d_a  [N];
  logic         hv_a [N];
  logic         av_a [N];
  logic         al_a [N];

  logic [N-1:0]    s_hdr_tvalid, s_hdr_trdy, s_axis_tvalid, s_axis_tlast, s_axis_trdy;
  logic [16*N-1:0] s_udp_src_port, s_udp_dst_port, s_udp_length;
  logic [W*N-1:0]  s_axis_tdata;
  logic            m_udp_hdr_tvalid, m_udp_hdr_trdy;
  logic [15:0]     m_udp_src_port, m_udp_dst_port, m_udp_length;
  logic [W-1:0]    m_axis_tdata;
  logic            m_axis_tvalid, m_axis_tlast, m_axis_trdy;
  logic [1:0]      o_grant_idx;
  logic            o_busy;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      s_hdr_tvalid[k]           = hv_a[k];
      s_udp_src_port[16*k +: 16] = sp_a[k];
      s_udp_dst_port[16*k +: 16] = dp_a[k];
      s_udp_length[16*k +: 16]   = ln_a[k];
      s_axis_tdata[W*k +: W]     = d_a[k];
      s_axis_tvalid[k]           = av_a[k];
      s_axis_tlast[k]            = al_a[k];
    end
  end

  udp_tx_arbiter #(.AXI_DATA_WIDTH(W), .NUM_SRC(N)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .s_hdr_tvalid     (s_hdr_tvalid),
    .s_hdr_trdy       (s_hdr_trdy),
    .s_udp_src_port   (s_udp_src_port),
    .s_udp_dst_port   (s_udp_dst_port),
    .s_udp_length     (s_udp_length),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_trdy      (s_axis_trdy),
    .m_udp_hdr_tvalid (m_udp_hdr_tvalid),
    .m_udp_hdr_trdy   (m_udp_hdr_trdy),
    .m_udp_src_port   (m_udp_src_port),
    .m_udp_dst_port   (m_udp_dst_port),
    .m_udp_length     (m_udp_length),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_trdy      (m_axis_trdy),
    .o_grant_idx      (o_grant_idx),
    .o_busy           (o_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  hdr_t         hq[$];
  logic [W:0]   bq[$];

  task automatic expect_pkt(input int k, input logic [15:0] sp, input logic [15:0] dp,
                            input logic [15:0] ln, input int nbeats, input int nsend,
                            input logic [W-1:0] base);
    hdr_t h;
    h.sp  = sp;
    h.dp  = dp;
    h.ln  = ln;
    h.idx = 2'(k);
    hq.push_back(h);
    for (int b = 0; b < nsend; b++) begin
      logic [W-1:0] dv;
      logic         lv;
      dv = base + W'(b);
      lv = (b == nbeats - 1);
      bq.push_back({lv, dv});
    end
  endtask

  task automatic send_pkt(input int k, input logic [15:0] sp, input logic [15:0] dp,
                          input logic [15:0] ln, input int nbeats, input int nsend,
                          input logic [W-1:0] base);
    bit hs;
    int budget;
    sp_a[k] = sp;
    dp_a[k] = dp;
    ln_a[k] = ln;
    hv_a[k] = 1'b1;
    hs = 0;
    budget = 0;
    while (!hs && budget < 200) begin
      @(negedge clk);
      hs = s_hdr_trdy[k];
      if (hs) chk("hdr_trdy_onehot", 64'(s_hdr_trdy), 64'(1 << k));
      @(posedge clk);
      #1;
      budget++;
    end
    hv_a[k] = 1'b0;
    if (!hs) begin
      chk("hdr_grant_timeout", 0, 1);
      return;
    end
    @(negedge clk);
    chk("hdr_valid_latency", 64'(m_udp_hdr_tvalid), 1);
    for (int b = 0; b < nsend; b++) begin
      d_a[k]  = base + W'(b);
      av_a[k] = 1'b1;
      al_a[k] = (b == nbeats - 1);
      hs = 0;
      budget = 0;
      while (!hs && budget < 200) begin
        @(negedge clk);
        hs = s_axis_trdy[k];
        @(posedge clk);
        #1;
        budget++;
      end
      if (!hs) begin
        chk("beat_timeout", 0, 1);
        break;
      end
    end
    av_a[k] = 1'b0;
    al_a[k] = 1'b0;
  endtask

  hdr_t       mon_h;
  logic [W:0] mon_b;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_udp_hdr_tvalid) begin
        if (hq.size() == 0) chk("hdr_unexpected", 1, 0);
        else begin
          mon_h = hq[0];
          chk("hdr_fields", {m_udp_src_port, m_udp_dst_port, m_udp_length},
              {mon_h.sp, mon_h.dp, mon_h.ln});
          chk("grant_idx", 64'(o_grant_idx), 64'(mon_h.idx));
          if (m_udp_hdr_trdy) mon_h = hq.pop_front();
        end
      end
      if (m_axis_tvalid) begin
        if (bq.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          mon_b = bq[0];
          chk("beat_last_data", 64'({m_axis_tlast, m_axis_tdata}), 64'(mon_b));
          if (m_axis_trdy) mon_b = bq.pop_front();
        end
      end
      if (o_busy && s_hdr_tvalid != '0) chk("hdr_trdy_while_busy", 64'(s_hdr_trdy), 0);
    end
  end

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      sp_a[k] = '0; dp_a[k] = '0; ln_a[k] = '0; d_a[k] = '0;
      hv_a[k] = 1'b0; av_a[k] = 1'b0; al_a[k] = 1'b0;
    end
    rst = 1'b1;
    m_udp_hdr_trdy = 1'b1;
    m_axis_trdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_hdr_tvalid", 64'(m_udp_hdr_tvalid), 0);
    chk("rst_axis_tvalid", 64'(m_axis_tvalid), 0);
    chk("rst_grant_idx", 64'(o_grant_idx), 0);
    chk("rst_hdr_regs", {m_udp_src_port, m_udp_dst_port, m_udp_length}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All four request continuously: grant order 0,1,2,3,0,1
    expect_pkt(0, 16'hA000, 16'hB000, 16'd10, 2, 2, 8'h00);
    expect_pkt(1, 16'hA010, 16'hB010, 16'd10, 2, 2, 8'h10);
    expect_pkt(2, 16'hA020, 16'hB020, 16'd10, 2, 2, 8'h20);
    expect_pkt(3, 16'hA030, 16'hB030, 16'd10, 2, 2, 8'h30);
    expect_pkt(0, 16'hA001, 16'hB001, 16'd10, 2, 2, 8'h04);
    expect_pkt(1, 16'hA011, 16'hB011, 16'd10, 2, 2, 8'h14);
    fork
      begin
        send_pkt(0, 16'hA000, 16'hB000, 16'd10, 2, 2, 8'h00);
        send_pkt(0, 16'hA001, 16'hB001, 16'd10, 2, 2, 8'h04);
      end
      begin
        send_pkt(1, 16'hA010, 16'hB010, 16'd10, 2, 2, 8'h10);
        send_pkt(1, 16'hA011, 16'hB011, 16'd10, 2, 2, 8'h14);
      end
      send_pkt(2, 16'hA020, 16'hB020, 16'd10, 2, 2, 8'h20);
      send_pkt(3, 16'hA030, 16'hB030, 16'd10, 2, 2, 8'h30);
    join
    settle();

    // Single source 2, four beats
    expect_pkt(2, 16'h1234, 16'h0050, 16'd12, 4, 4, 8'hA0);
    send_pkt(2, 16'h1234, 16'h0050, 16'd12, 4, 4, 8'hA0);
    settle();

    // Header stalled 5 cycles, payload ready pattern 1,0,0,1
    m_udp_hdr_trdy = 1'b0;
    expect_pkt(2, 16'h3333, 16'h0044, 16'd11, 3, 3, 8'h50);
    fork
      send_pkt(2, 16'h3333, 16'h0044, 16'd11, 3, 3, 8'h50);
      begin
        int budget;
        logic [3:0] pat;
        pat = 4'b1001;
        budget = 0;
        while (!m_udp_hdr_tvalid && budget < 100) begin
          @(negedge clk);
          budget++;
        end
        chk("stall_hdr_seen", 64'(m_udp_hdr_tvalid), 1);
        repeat (5) @(posedge clk);
        #1;
        m_udp_hdr_trdy = 1'b1;
        budget = 0;
        while (!m_axis_tvalid && budget < 100) begin
          @(negedge clk);
          budget++;
        end
        chk("stall_beat_seen", 64'(m_axis_tvalid), 1);
        for (int i = 3; i >= 0; i--) begin
          m_axis_trdy = pat[i];
          @(posedge clk);
          #1;
        end
        m_axis_trdy = 1'b1;
      end
    join
    settle();

    // Source 3 requests while source 1 is mid-payload
    expect_pkt(1, 16'h0101, 16'h0202, 16'd11, 3, 3, 8'h60);
    expect_pkt(3, 16'h0303, 16'h0404, 16'd9, 1, 1, 8'h70);
    fork
      send_pkt(1, 16'h0101, 16'h0202, 16'd11, 3, 3, 8'h60);
      begin
        repeat (3) @(posedge clk);
        #1;
        send_pkt(3, 16'h0303, 16'h0404, 16'd9, 1, 1, 8'h70);
      end
    join
    settle();

    // One-beat packet then a normal one
    expect_pkt(0, 16'h0009, 16'h0900, 16'd9, 1, 1, 8'h80);
    expect_pkt(1, 16'h0019, 16'h0910, 16'd10, 2, 2, 8'h90);
    send_pkt(0, 16'h0009, 16'h0900, 16'd9, 1, 1, 8'h80);
    send_pkt(1, 16'h0019, 16'h0910, 16'd10, 2, 2, 8'h90);
    settle();

    // Reset after 2 of 5 beats
    expect_pkt(0, 16'h0E0E, 16'h0F0F, 16'd13, 5, 2, 8'hB0);
    send_pkt(0, 16'h0E0E, 16'h0F0F, 16'd13, 5, 2, 8'hB0);
    chk("abort_busy_before_reset", 64'(o_busy), 1);
    d_a[0]  = 8'hB2;
    av_a[0] = 1'b1;
    sp_a[3] = 16'h7777;
    hv_a[3] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_s_hdr_trdy", 64'(s_hdr_trdy), 0);
    chk("rst_mid_s_axis_trdy", 64'(s_axis_trdy), 0);
    chk("rst_mid_axis_tvalid", 64'(m_axis_tvalid), 0);
    chk("rst_mid_hdr_tvalid", 64'(m_udp_hdr_tvalid), 0);
    chk("rst_mid_busy", 64'(o_busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    av_a[0] = 1'b0;
    hv_a[3] = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(o_busy), 0);
    chk("post_rst_grant_idx", 64'(o_grant_idx), 0);
    @(posedge clk);
    #1;
    expect_pkt(0, 16'h0C00, 16'h0C01, 16'd10, 2, 2, 8'hC0);
    expect_pkt(3, 16'h0D00, 16'h0D01, 16'd10, 2, 2, 8'hD0);
    fork
      send_pkt(0, 16'h0C00, 16'h0C01, 16'd10, 2, 2, 8'hC0);
      send_pkt(3, 16'h0D00, 16'h0D01, 16'd10, 2, 2, 8'hD0);
    join
    settle();

    chk("hdr_queue_drained", 64'(hq.size()), 0);
    chk("beat_queue_drained", 64'(bq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
